isqrt_seq: RTL

Parametrised sequential integer square root unit: for an unsigned WIDTH-bit operand it returns floor(sqrt(a)) and the remainder a - root², one root bit per clock, using the binary restoring digit-by-digit method. It replaces the fixed 8-bit odd-number-summation datapath. Latency is fixed at WIDTH/2 iterations, independent of the operand. A start/ready/done handshake lets it sit behind any controller or bus register block.

---
 rtl/isqrt_pkg.sv | 29 ++
 rtl/isqrt_step.sv | 34 +++
 rtl/isqrt_seq.sv | 89 ++++++++
 3 files changed

// File: rtl/isqrt_pkg.sv
// rtl/isqrt_pkg.sv - shared types, sizing helpers and width rule for the integer square root unit
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } isqrt_state_t;

    // Each iteration consumes one operand bit pair, so the width must be a positive multiple of two.
    localparam int MIN_WIDTH      = 2;
    localparam int WIDTH_MULTIPLE = 2;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && ((w % WIDTH_MULTIPLE) == 0);
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/isqrt_step.sv
// rtl/isqrt_step.sv - one combinational restoring square-root iteration
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int ROOT_W = 8
) (
    input  logic [ROOT_W:0]   r,
    input  logic [ROOT_W-1:0] q,
    input  logic [1:0]        bits,
    output logic [ROOT_W:0]   r_next,
    output logic [ROOT_W-1:0] q_next
);

    logic [ROOT_W+2:0] trial;
    logic [ROOT_W+2:0] sub;
    logic [ROOT_W+2:0] diff;
    logic              fits;
    logic [ROOT_W:0]   q_wide;

    assign trial = {r, bits};
    assign sub   = {1'b0, q, 2'b01};
    assign diff  = trial - sub;
    // Extra top bit serves as the sign of the trial subtraction.
    assign fits  = ~diff[ROOT_W+2];

    // Surviving remainders are bounded by 2*root, so the dropped top bits are always zero.
    assign r_next = fits ? diff[ROOT_W:0] : trial[ROOT_W:0];
    assign q_wide = {q, fits};
    assign q_next = q_wide[ROOT_W-1:0];

    logic unused_bits;
    assign unused_bits = &{1'b0, diff[ROOT_W+1], trial[ROOT_W+2:ROOT_W+1], q_wide[ROOT_W]};

endmodule

// File: rtl/isqrt_seq.sv
// rtl/isqrt_seq.sv - sequential integer square root, one root bit per clock
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       a,
    output logic                   ready,
    output logic                   done,
    output logic [WIDTH/2-1:0]     root,
    output logic [WIDTH/2:0]       rem
);

    localparam int ROOT_W = WIDTH / 2;
    localparam int CNT_W  = (clog2(ROOT_W) > 0) ? clog2(ROOT_W) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("isqrt_seq: WIDTH must be even and at least 2");
    end

    isqrt_state_t      state;
    logic [WIDTH-1:0]  x;
    logic [ROOT_W:0]   r;
    logic [ROOT_W-1:0] q;
    logic [CNT_W-1:0]  cnt;
    logic [ROOT_W:0]   r_next;
    logic [ROOT_W-1:0] q_next;

    isqrt_step #(.ROOT_W(ROOT_W)) u_step (
        .r      (r),
        .q      (q),
        .bits   (x[WIDTH-1:WIDTH-2]),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x     <= '0;
            r     <= '0;
            q     <= '0;
            cnt   <= '0;
            root  <= '0;
            rem   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x     <= a;
                        r     <= '0;
                        q     <= '0;
                        cnt   <= CNT_W'(ROOT_W - 1);
                        state <= CALC;
                        ready <= 1'b0;
                    end
                end
                CALC: begin
                    x   <= x << 2;
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        root  <= q_next;
                        rem   <= r_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
